// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI constants, response/burst codes and slave FSM states
package axi_pkg;

  localparam int ID_W_DEF    = 8;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int LEN_W_DEF   = 4;
  localparam int SRAM_AW_DEF = 14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_R_ISSUE,
    S_R_DATA,
    S_W_DATA,
    S_W_RESP
  } state_t;

endpackage

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - single-transaction AXI4 INCR slave driving a 1-cycle synchronous SRAM
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ID_W    = ID_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int SRAM_AW = SRAM_AW_DEF,
  parameter int STRB_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   AWID_S,
  input  logic [ADDR_W-1:0] AWADDR_S,
  input  logic [LEN_W-1:0]  AWLEN_S,
  input  logic [2:0]        AWSIZE_S,
  input  logic [1:0]        AWBURST_S,
  input  logic              AWVALID_S,
  output logic              AWREADY_S,
  input  logic [DATA_W-1:0] WDATA_S,
  input  logic [STRB_W-1:0] WSTRB_S,
  input  logic              WLAST_S,
  input  logic              WVALID_S,
  output logic              WREADY_S,
  output logic [ID_W-1:0]   BID_S,
  output logic [1:0]        BRESP_S,
  output logic              BVALID_S,
  input  logic              BREADY_S,
  input  logic [ID_W-1:0]   ARID_S,
  input  logic [ADDR_W-1:0] ARADDR_S,
  input  logic [LEN_W-1:0]  ARLEN_S,
  input  logic [2:0]        ARSIZE_S,
  input  logic [1:0]        ARBURST_S,
  input  logic              ARVALID_S,
  output logic              ARREADY_S,
  output logic [ID_W-1:0]   RID_S,
  output logic [DATA_W-1:0] RDATA_S,
  output logic [1:0]        RRESP_S,
  output logic              RLAST_S,
  output logic              RVALID_S,
  input  logic              RREADY_S,
  output logic              CEB,
  output logic              WEB,
  output logic [DATA_W-1:0] BWEB,
  output logic [SRAM_AW-1:0] A,
  output logic [DATA_W-1:0] DI,
  input  logic [DATA_W-1:0] DO
);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     id_q;
  logic [SRAM_AW-1:0]  addr_q;
  logic [LEN_W-1:0]    len_q, cnt_q;
  logic                err_q;

  logic aw_hs, ar_hs, r_hs, w_hs, last_beat;

  assign aw_hs     = AWREADY_S & AWVALID_S;
  assign ar_hs     = ARREADY_S & ARVALID_S;
  assign r_hs      = (state == S_R_DATA) & RREADY_S;
  assign w_hs      = (state == S_W_DATA) & WVALID_S;
  assign last_beat = (cnt_q == len_q);

  assign BID_S   = id_q;
  assign RID_S   = id_q;
  assign RDATA_S = DO;

  logic unused_bits;
  assign unused_bits = ^{AWSIZE_S, ARSIZE_S, AWADDR_S[1:0], ARADDR_S[1:0],
                         AWADDR_S[ADDR_W-1:SRAM_AW+2], ARADDR_S[ADDR_W-1:SRAM_AW+2]};

  always_comb begin
    state_nxt = state;
    AWREADY_S = 1'b0;
    ARREADY_S = 1'b0;
    WREADY_S  = 1'b0;
    BVALID_S  = 1'b0;
    BRESP_S   = RESP_OKAY;
    RVALID_S  = 1'b0;
    RRESP_S   = RESP_OKAY;
    RLAST_S   = 1'b0;
    CEB       = 1'b1;
    WEB       = 1'b1;
    BWEB      = '1;
    A         = addr_q;
    DI        = '0;
    case (state)
      S_IDLE: begin
        // Ready is suppressed while reset is held so nothing looks accepted.
        AWREADY_S = ~rst;
        ARREADY_S = ~rst & ~AWVALID_S;
        if (aw_hs)      state_nxt = S_W_DATA;
        else if (ar_hs) state_nxt = S_R_ISSUE;
      end
      S_R_ISSUE: begin
        CEB       = 1'b0;
        state_nxt = S_R_DATA;
      end
      S_R_DATA: begin
        RVALID_S = 1'b1;
        RLAST_S  = last_beat;
        RRESP_S  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (r_hs) begin
          if (last_beat) begin
            state_nxt = S_IDLE;
          end else begin
            // Prefetch the next word so the following cycle has fresh DO.
            CEB = 1'b0;
            A   = addr_q + 1'b1;
          end
        end
      end
      S_W_DATA: begin
        WREADY_S = 1'b1;
        if (w_hs) begin
          if (|WSTRB_S) begin
            CEB = 1'b0;
            WEB = 1'b0;
            DI  = WDATA_S;
            for (int i = 0; i < STRB_W; i++) BWEB[i*8 +: 8] = {8{~WSTRB_S[i]}};
          end
          if (last_beat) state_nxt = S_W_RESP;
        end
      end
      S_W_RESP: begin
        BVALID_S = 1'b1;
        BRESP_S  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (BREADY_S) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (aw_hs) begin
            id_q   <= AWID_S;
            addr_q <= AWADDR_S[SRAM_AW+1:2];
            len_q  <= AWLEN_S;
            cnt_q  <= '0;
            err_q  <= (AWBURST_S != BURST_INCR);
          end else if (ar_hs) begin
            id_q   <= ARID_S;
            addr_q <= ARADDR_S[SRAM_AW+1:2];
            len_q  <= ARLEN_S;
            cnt_q  <= '0;
            err_q  <= (ARBURST_S != BURST_INCR);
          end
        end
        S_R_DATA: begin
          if (r_hs && !last_beat) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        S_W_DATA: begin
          if (w_hs) begin
            if (WLAST_S != last_beat) err_q <= 1'b1;
            if (!last_beat) begin
              addr_q <= addr_q + 1'b1;
              cnt_q  <= cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed bench for axi_sram_slave with a behavioural SRAM
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  AWID_S, ARID_S, BID_S, RID_S;
  logic [31:0] AWADDR_S, ARADDR_S;
  logic [3:0]  AWLEN_S, ARLEN_S;
  logic [2:0]  AWSIZE_S, ARSIZE_S;
  logic [1:0]  AWBURST_S, ARBURST_S, BRESP_S, RRESP_S;
  logic        AWVALID_S, AWREADY_S, ARVALID_S, ARREADY_S;
  logic [31:0] WDATA_S, RDATA_S;
  logic [3:0]  WSTRB_S;
  logic        WLAST_S, WVALID_S, WREADY_S, BVALID_S, BREADY_S;
  logic        RLAST_S, RVALID_S, RREADY_S;
  logic        CEB, WEB;
  logic [31:0] BWEB, DI, DO;
  logic [13:0] A;

  logic [31:0] mem [0:16383];
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!CEB) begin
      if (!WEB) mem[A] <= (mem[A] & BWEB) | (DI & ~BWEB);
      else      DO <= mem[A];
    end
  end

  axi_sram_slave dut (
    .clk(clk), .rst(rst),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
    .BREADY_S(BREADY_S), .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S),
    .ARREADY_S(ARREADY_S), .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
    .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
    int n = 0;
    AWID_S = id; AWADDR_S = addr; AWLEN_S = len; AWSIZE_S = 3'd2; AWBURST_S = burst;
    AWVALID_S = 1'b1;
    #1;
    while (!AWREADY_S && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      total_cnt++;
      $display("FAIL aw_timeout: AWREADY_S stayed %b, required 1", AWREADY_S);
    end
    @(posedge clk); #1;
    AWVALID_S = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
    int n = 0;
    ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARSIZE_S = 3'd2; ARBURST_S = burst;
    ARVALID_S = 1'b1;
    #1;
    while (!ARREADY_S && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      total_cnt++;
      $display("FAIL ar_timeout: ARREADY_S stayed %b, required 1", ARREADY_S);
    end
    @(posedge clk); #1;
    ARVALID_S = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    WDATA_S = data; WSTRB_S = strb; WLAST_S = last; WVALID_S = 1'b1;
    #1;
    while (!WREADY_S && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      total_cnt++;
      $display("FAIL w_timeout: WREADY_S stayed %b, required 1", WREADY_S);
    end
    @(posedge clk); #1;
    WVALID_S = 1'b0;
  endtask

  task automatic b_accept();
    BREADY_S = 1'b1;
    tick();
    BREADY_S = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    AWVALID_S = 0; ARVALID_S = 0; WVALID_S = 0; BREADY_S = 0; RREADY_S = 0;
    AWID_S = 0; AWADDR_S = 0; AWLEN_S = 0; AWSIZE_S = 0; AWBURST_S = 0;
    ARID_S = 0; ARADDR_S = 0; ARLEN_S = 0; ARSIZE_S = 0; ARBURST_S = 0;
    WDATA_S = 0; WSTRB_S = 0; WLAST_S = 0;
    repeat (2) tick();
    total_cnt++;
    if ({AWREADY_S, ARREADY_S, WREADY_S, BVALID_S, RVALID_S, RLAST_S} !== 6'b0)
      $display("FAIL reset_handshake: got %b, required 000000",
               {AWREADY_S, ARREADY_S, WREADY_S, BVALID_S, RVALID_S, RLAST_S});
    else pass_cnt++;
    total_cnt++;
    if ({CEB, WEB, BWEB, A, DI, BID_S, RID_S, BRESP_S, RRESP_S} !== {2'b11, 32'hFFFF_FFFF, 14'd0, 32'd0, 8'd0, 8'd0, 4'd0})
      $display("FAIL reset_sram: CEB=%b WEB=%b BWEB=%h A=%h DI=%h, required 1 1 ffffffff 0 0",
               CEB, WEB, BWEB, A, DI);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (AWREADY_S !== 1'b1) $display("FAIL idle_awready: got %b, required 1", AWREADY_S);
    else pass_cnt++;
  endtask

  task automatic test_single_rw();
    send_aw(8'h11, 32'h10, 4'd0, 2'b01);
    total_cnt++;
    if (WREADY_S !== 1'b1) $display("FAIL aw_to_wready: got %b, required 1", WREADY_S);
    else pass_cnt++;
    w_beat(32'hDEADBEEF, 4'hF, 1'b1);
    total_cnt++;
    if ({BVALID_S, BRESP_S, BID_S} !== {1'b1, 2'b00, 8'h11})
      $display("FAIL single_b: got v=%b resp=%b id=%h, required 1 00 11", BVALID_S, BRESP_S, BID_S);
    else pass_cnt++;
    b_accept();
    total_cnt++;
    if (mem[4] !== 32'hDEADBEEF) $display("FAIL single_mem: got %h, required deadbeef", mem[4]);
    else pass_cnt++;
    send_ar(8'h22, 32'h10, 4'd0, 2'b01);
    total_cnt++;
    if ({RVALID_S, CEB, WEB, A} !== {1'b0, 1'b0, 1'b1, 14'd4})
      $display("FAIL r_issue: RVALID=%b CEB=%b WEB=%b A=%0d, required 0 0 1 4", RVALID_S, CEB, WEB, A);
    else pass_cnt++;
    tick();
    RREADY_S = 1'b1;
    #1;
    total_cnt++;
    if ({RVALID_S, RDATA_S, RLAST_S, RID_S, RRESP_S} !== {1'b1, 32'hDEADBEEF, 1'b1, 8'h22, 2'b00})
      $display("FAIL single_r: v=%b data=%h last=%b id=%h resp=%b, required 1 deadbeef 1 22 00",
               RVALID_S, RDATA_S, RLAST_S, RID_S, RRESP_S);
    else pass_cnt++;
    tick();
    RREADY_S = 1'b0;
    #1;
    total_cnt++;
    if (RVALID_S !== 1'b0) $display("FAIL single_r_end: RVALID got %b, required 0", RVALID_S);
    else pass_cnt++;
  endtask

  task automatic test_burst_read();
    logic [31:0] exp_d [4] = '{32'hA0A0_0008, 32'hA0A0_0009, 32'hA0A0_000A, 32'hA0A0_000B};
    logic        tog [12] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1};
    int beat;
    for (int i = 0; i < 4; i++) mem[8+i] = exp_d[i];
    send_ar(8'h05, 32'h20, 4'd3, 2'b01);
    tick();
    RREADY_S = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++;
      if ({RVALID_S, RDATA_S, RLAST_S} !== {1'b1, exp_d[i], (i == 3)})
        $display("FAIL burst_beat%0d: v=%b data=%h last=%b, required 1 %h %b",
                 i, RVALID_S, RDATA_S, RLAST_S, exp_d[i], (i == 3));
      else pass_cnt++;
      tick();
    end
    RREADY_S = 1'b0;
    send_ar(8'h06, 32'h20, 4'd3, 2'b01);
    tick();
    beat = 0;
    for (int c = 0; c < 12 && beat < 4; c++) begin
      RREADY_S = tog[c];
      #1;
      total_cnt++;
      if (RVALID_S !== 1'b1 || RDATA_S !== exp_d[beat] || (!tog[c] && CEB !== 1'b1))
        $display("FAIL toggle_c%0d: v=%b data=%h CEB=%b, required 1 %h %b",
                 c, RVALID_S, RDATA_S, CEB, exp_d[beat], !tog[c] ? 1'b1 : CEB);
      else pass_cnt++;
      tick();
      if (tog[c]) beat++;
    end
    RREADY_S = 1'b0;
    total_cnt++;
    if (beat != 4 || RVALID_S !== 1'b0)
      $display("FAIL toggle_done: beats=%0d RVALID=%b, required 4 0", beat, RVALID_S);
    else pass_cnt++;
  endtask

  task automatic test_partial_write();
    send_aw(8'h01, 32'h40, 4'd0, 2'b01);
    w_beat(32'hFFFF_FFFF, 4'hF, 1'b1);
    b_accept();
    send_aw(8'h01, 32'h40, 4'd0, 2'b01);
    WDATA_S = 32'h11223344; WSTRB_S = 4'b0101; WLAST_S = 1'b1; WVALID_S = 1'b1;
    #1;
    total_cnt++;
    if ({CEB, WEB, BWEB} !== {2'b00, 32'hFF00_FF00})
      $display("FAIL partial_bweb: CEB=%b WEB=%b BWEB=%h, required 0 0 ff00ff00", CEB, WEB, BWEB);
    else pass_cnt++;
    tick();
    WVALID_S = 1'b0;
    b_accept();
    send_ar(8'h01, 32'h40, 4'd0, 2'b01);
    tick();
    RREADY_S = 1'b1;
    #1;
    total_cnt++;
    if (RDATA_S !== 32'hFF22FF44) $display("FAIL partial_read: got %h, required ff22ff44", RDATA_S);
    else pass_cnt++;
    tick();
    RREADY_S = 1'b0;
  endtask

  task automatic test_write_priority();
    AWID_S = 8'h31; AWADDR_S = 32'h80; AWLEN_S = 0; AWBURST_S = 2'b01; AWVALID_S = 1'b1;
    ARID_S = 8'h32; ARADDR_S = 32'h80; ARLEN_S = 0; ARBURST_S = 2'b01; ARVALID_S = 1'b1;
    #1;
    total_cnt++;
    if ({AWREADY_S, ARREADY_S} !== 2'b10)
      $display("FAIL prio_idle: AWREADY=%b ARREADY=%b, required 1 0", AWREADY_S, ARREADY_S);
    else pass_cnt++;
    tick();
    AWVALID_S = 1'b0;
    #1;
    total_cnt++;
    if ({ARREADY_S, WREADY_S} !== 2'b01)
      $display("FAIL prio_wdata: ARREADY=%b WREADY=%b, required 0 1", ARREADY_S, WREADY_S);
    else pass_cnt++;
    w_beat(32'h0BAD_F00D, 4'hF, 1'b1);
    total_cnt++;
    if ({ARREADY_S, BVALID_S} !== 2'b01)
      $display("FAIL prio_wresp: ARREADY=%b BVALID=%b, required 0 1", ARREADY_S, BVALID_S);
    else pass_cnt++;
    b_accept();
    total_cnt++;
    if (ARREADY_S !== 1'b1) $display("FAIL prio_after_b: ARREADY got %b, required 1", ARREADY_S);
    else pass_cnt++;
    tick();
    ARVALID_S = 1'b0;
    tick();
    RREADY_S = 1'b1;
    #1;
    total_cnt++;
    if ({RDATA_S, RID_S} !== {32'h0BAD_F00D, 8'h32})
      $display("FAIL prio_read: data=%h id=%h, required 0badf00d 32", RDATA_S, RID_S);
    else pass_cnt++;
    tick();
    RREADY_S = 1'b0;
  endtask

  task automatic test_errors();
    send_aw(8'h41, 32'h100, 4'd3, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(32'h5000 + i, 4'hF, (i == 1));
    total_cnt++;
    if ({BVALID_S, BRESP_S} !== {1'b1, 2'b10} || mem[67] !== 32'h5003)
      $display("FAIL wlast_err: v=%b resp=%b mem67=%h, required 1 10 00005003", BVALID_S, BRESP_S, mem[67]);
    else pass_cnt++;
    b_accept();
    send_aw(8'h42, 32'h200, 4'd0, 2'b10);
    w_beat(32'h7777, 4'hF, 1'b1);
    total_cnt++;
    if ({BVALID_S, BRESP_S, mem[128]} !== {1'b1, 2'b10, 32'h7777})
      $display("FAIL burst_err: v=%b resp=%b mem=%h, required 1 10 00007777", BVALID_S, BRESP_S, mem[128]);
    else pass_cnt++;
    b_accept();
    send_aw(8'h43, 32'h204, 4'd0, 2'b01);
    w_beat(32'h8888, 4'hF, 1'b1);
    total_cnt++;
    if (BRESP_S !== 2'b00) $display("FAIL err_cleared: BRESP got %b, required 00", BRESP_S);
    else pass_cnt++;
    b_accept();
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 4; i++) mem[300+i] = 32'hC000 + i;
    send_ar(8'h51, 32'd1200, 4'd3, 2'b01);
    tick();
    RREADY_S = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({RVALID_S, CEB} !== 2'b01)
      $display("FAIL rst_mid: RVALID=%b CEB=%b, required 0 1", RVALID_S, CEB);
    else pass_cnt++;
    RREADY_S = 1'b0;
    tick();
    rst = 1'b0;
    send_ar(8'h52, 32'd1208, 4'd0, 2'b01);
    tick();
    RREADY_S = 1'b1;
    #1;
    total_cnt++;
    if ({RVALID_S, RDATA_S, RLAST_S, RID_S} !== {1'b1, 32'hC002, 1'b1, 8'h52})
      $display("FAIL rst_fresh: v=%b data=%h last=%b id=%h, required 1 0000c002 1 52",
               RVALID_S, RDATA_S, RLAST_S, RID_S);
    else pass_cnt++;
    tick();
    RREADY_S = 1'b0;
  endtask

  task automatic test_wrap();
    send_aw(8'h61, 32'h0000_FFFC, 4'd1, 2'b01);
    WDATA_S = 32'hA1; WSTRB_S = 4'hF; WLAST_S = 1'b0; WVALID_S = 1'b1;
    #1;
    total_cnt++;
    if ({CEB, A} !== {1'b0, 14'h3FFF}) $display("FAIL wrap_a0: CEB=%b A=%h, required 0 3fff", CEB, A);
    else pass_cnt++;
    tick();
    WDATA_S = 32'hB2; WLAST_S = 1'b1;
    #1;
    total_cnt++;
    if ({CEB, A} !== {1'b0, 14'h0}) $display("FAIL wrap_a1: CEB=%b A=%h, required 0 0000", CEB, A);
    else pass_cnt++;
    tick();
    WVALID_S = 1'b0;
    total_cnt++;
    if ({BRESP_S, mem[16383], mem[0]} !== {2'b00, 32'hA1, 32'hB2})
      $display("FAIL wrap_mem: resp=%b top=%h zero=%h, required 00 000000a1 000000b2",
               BRESP_S, mem[16383], mem[0]);
    else pass_cnt++;
    b_accept();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    DO = 32'h0;
    test_reset();
    test_single_rw();
    test_burst_read();
    test_partial_write();
    test_write_priority();
    test_errors();
    test_reset_mid_read();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
